// File: rtl/wb_arbiter.sv
// Purpose : writeback arbiter merging ALU results and queued load returns into one regfile write port.
// Latency : 1 cycle from selection to wr_*; loads bypass the queue when it is empty and no ALU result is present.
// Backpress: ALU never stalls; ld_rdy drops when the load queue holds LD_DEPTH entries (count-based, even on pop).
//
// Ports: clk/rst_n (async active-low); alu_vld/alu_trd/alu_reg/alu_data ALU result;
//        ld_vld/ld_rdy/ld_trd/ld_reg/ld_data load return handshake; flush/flush_trd per-thread kill;
//        wr_en/wr_trd/reg_wr/wr_data registered regfile write; ld_cnt queue occupancy (incl. flushed).
// Optional: define WB_PERF_EN to add perf_conflict, a saturating count of cycles where an ALU result
//           blocked a valid queued load.
module wb_arbiter #(
    parameter int LD_DEPTH = 4,
    parameter int PERF_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_vld,
    input  logic [2:0]                 alu_trd,
    input  logic [4:0]                 alu_reg,
    input  logic [31:0]                alu_data,
    input  logic                       ld_vld,
    output logic                       ld_rdy,
    input  logic [2:0]                 ld_trd,
    input  logic [4:0]                 ld_reg,
    input  logic [31:0]                ld_data,
    input  logic                       flush,
    input  logic [2:0]                 flush_trd,
    output logic                       wr_en,
    output logic [2:0]                 wr_trd,
    output logic [4:0]                 reg_wr,
    output logic [31:0]                wr_data,
`ifdef WB_PERF_EN
    output logic [PERF_W-1:0]          perf_conflict,
`endif
    output logic [$clog2(LD_DEPTH):0]  ld_cnt
);

    localparam int AW = $clog2(LD_DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(LD_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    // load-return queue storage
    logic        q_vld  [LD_DEPTH];
    logic [2:0]  q_trd  [LD_DEPTH];
    logic [4:0]  q_reg  [LD_DEPTH];
    logic [31:0] q_data [LD_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    logic        fifo_empty, head_live, ld_acc, ld_kill, bypass, push, pop;
    logic        issue;
    logic [2:0]  issue_trd;
    logic [4:0]  issue_reg;
    logic [31:0] issue_data;

    assign ld_rdy     = (ld_cnt != FULL_CNT);
    assign fifo_empty = (ld_cnt == '0);
    assign ld_acc     = ld_vld && ld_rdy;
    assign ld_kill    = flush && (ld_trd == flush_trd);
    // A head being flushed this very cycle is treated as already dead so a
    // killed thread is never written after its flush cycle.
    assign head_live  = !fifo_empty && q_vld[rd_ptr] && !(flush && (q_trd[rd_ptr] == flush_trd));
    // Killed loads still go through the queue (as invalid) so the handshake stays simple.
    assign bypass     = fifo_empty && !alu_vld && ld_acc && !ld_kill;
    assign push       = ld_acc && !bypass;
    // Dead heads drain even while the ALU owns the port; live heads wait.
    assign pop        = !fifo_empty && (!alu_vld || !head_live);

    always_comb begin
        issue      = 1'b0;
        issue_trd  = alu_trd;
        issue_reg  = alu_reg;
        issue_data = alu_data;
        if (alu_vld) begin
            issue = 1'b1;
        end else if (head_live) begin
            issue      = 1'b1;
            issue_trd  = q_trd[rd_ptr];
            issue_reg  = q_reg[rd_ptr];
            issue_data = q_data[rd_ptr];
        end else if (bypass) begin
            issue      = 1'b1;
            issue_trd  = ld_trd;
            issue_reg  = ld_reg;
            issue_data = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            ld_cnt <= '0;
            for (int i = 0; i < LD_DEPTH; i++) begin
                q_vld[i]  <= 1'b0;
                q_trd[i]  <= '0;
                q_reg[i]  <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (flush) begin
                for (int i = 0; i < LD_DEPTH; i++) begin
                    if (q_trd[i] == flush_trd) q_vld[i] <= 1'b0;
                end
            end
            // Written after the flush loop; the slot at wr_ptr is free whenever push is allowed.
            if (push) begin
                q_vld[wr_ptr]  <= !ld_kill;
                q_trd[wr_ptr]  <= ld_trd;
                q_reg[wr_ptr]  <= ld_reg;
                q_data[wr_ptr] <= ld_data;
                wr_ptr         <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   ld_cnt <= ld_cnt + CNT_ONE;
                2'b01:   ld_cnt <= ld_cnt - CNT_ONE;
                default: ld_cnt <= ld_cnt;
            endcase
        end
    end

    // r0 is hardwired zero: the result is consumed but the write strobe is suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_trd  <= '0;
            reg_wr  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= issue && (issue_reg != 5'd0);
            if (issue) begin
                wr_trd  <= issue_trd;
                reg_wr  <= issue_reg;
                wr_data <= issue_data;
            end
        end
    end

`ifdef WB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conflict <= '0;
        end else if (alu_vld && head_live && (perf_conflict != '1)) begin
            perf_conflict <= perf_conflict + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int PW    = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_vld;
    logic [2:0]  alu_trd;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        ld_vld;
    logic        ld_rdy;
    logic [2:0]  ld_trd;
    logic [4:0]  ld_reg;
    logic [31:0] ld_data;
    logic        flush;
    logic [2:0]  flush_trd;
    logic        wr_en;
    logic [2:0]  wr_trd;
    logic [4:0]  reg_wr;
    logic [31:0] wr_data;
    logic [$clog2(DEPTH):0] ld_cnt;
`ifdef WB_PERF_EN
    logic [PW-1:0] perf_conflict;
`endif

    wb_arbiter #(.LD_DEPTH(DEPTH), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_vld(alu_vld), .alu_trd(alu_trd), .alu_reg(alu_reg), .alu_data(alu_data),
        .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_trd(ld_trd), .ld_reg(ld_reg), .ld_data(ld_data),
        .flush(flush), .flush_trd(flush_trd),
        .wr_en(wr_en), .wr_trd(wr_trd), .reg_wr(reg_wr), .wr_data(wr_data),
`ifdef WB_PERF_EN
        .perf_conflict(perf_conflict),
`endif
        .ld_cnt(ld_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of pending loads plus the expected write port.
    typedef struct {
        bit          v;
        logic [2:0]  t;
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        exp_en;
    logic [2:0]  exp_trd;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    int          exp_perf;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input bit v, input int t, input int r, input logic [31:0] d);
        alu_vld = v; alu_trd = 3'(t); alu_reg = 5'(r); alu_data = d;
    endtask

    task automatic set_ld(input bit v, input int t, input int r, input logic [31:0] d);
        ld_vld = v; ld_trd = 3'(t); ld_reg = 5'(r); ld_data = d;
    endtask

    task automatic set_fl(input bit v, input int t);
        flush = v; flush_trd = 3'(t);
    endtask

    task automatic model_reset();
        q.delete();
        exp_en = 0; exp_trd = 0; exp_reg = 0; exp_data = 0; exp_perf = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".wr_en"},   32'(wr_en),   32'(exp_en));
        chk({tag, ".wr_trd"},  32'(wr_trd),  32'(exp_trd));
        chk({tag, ".reg_wr"},  32'(reg_wr),  32'(exp_reg));
        chk({tag, ".wr_data"}, wr_data,      exp_data);
`ifdef WB_PERF_EN
        chk({tag, ".perf"},    32'(perf_conflict), 32'(exp_perf));
`endif
    endtask

    // One clock: predict from the current inputs, advance, compare.
    task automatic cycle(input string tag);
        ent_t        e;
        bit          acc, kill, live, iss;
        logic [2:0]  it;
        logic [4:0]  ir;
        logic [31:0] id;
        chk({tag, ".ld_cnt"}, 32'(ld_cnt), 32'(q.size()));
        chk({tag, ".ld_rdy"}, 32'(ld_rdy), 32'(q.size() != DEPTH));
        acc  = ld_vld && (q.size() != DEPTH);
        kill = flush && (ld_trd == flush_trd);
        live = (q.size() > 0) && q[0].v && !(flush && q[0].t == flush_trd);
        iss = 0; it = 0; ir = 0; id = 0;
        if (alu_vld) begin
            iss = 1; it = alu_trd; ir = alu_reg; id = alu_data;
            if (q.size() > 0 && !live) e = q.pop_front();
        end else if (q.size() > 0) begin
            e = q.pop_front();
            if (live) begin iss = 1; it = e.t; ir = e.r; id = e.d; end
        end else if (acc && !kill) begin
            iss = 1; it = ld_trd; ir = ld_reg; id = ld_data;
            acc = 0;
        end
        if (alu_vld && live && exp_perf < (1 << PW) - 1) exp_perf++;
        if (flush) foreach (q[i]) if (q[i].t == flush_trd) q[i].v = 0;
        if (acc) begin
            e.v = !kill; e.t = ld_trd; e.r = ld_reg; e.d = ld_data;
            q.push_back(e);
        end
        exp_en = iss && (ir != 0);
        if (iss) begin exp_trd = it; exp_reg = ir; exp_data = id; end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle();
        set_alu(0, 0, 0, 0); set_ld(0, 0, 0, 0); set_fl(0, 0);
    endtask

    task automatic randomize_inputs();
        set_alu($urandom_range(0, 9) < 4, $urandom_range(0, 3), $urandom_range(0, 31), $urandom);
        set_ld($urandom_range(0, 9) < 6, $urandom_range(0, 3), $urandom_range(0, 31), $urandom);
        set_fl($urandom_range(0, 9) == 0, $urandom_range(0, 3));
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #12;
        chk("rst.wr_en",  32'(wr_en),  32'd0);
        chk("rst.ld_rdy", 32'(ld_rdy), 32'd1);
        chk("rst.ld_cnt", 32'(ld_cnt), 32'd0);
        check_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU write
        set_alu(1, 3, 5, 32'hDEADBEEF);
        cycle("alu");
        chk("alu.data_const", wr_data, 32'hDEADBEEF);
        idle();

        // Empty-queue bypass
        set_ld(1, 6, 9, 32'h1234);
        cycle("byp");
        chk("byp.en_const", 32'(wr_en), 32'd1);
        idle();
        cycle("byp_after");
        chk("byp.cnt_const", 32'(ld_cnt), 32'd0);

        // ALU pressure fills the queue, then drains in order
        for (int i = 0; i < 6; i++) begin
            set_alu(1, i, 10 + i, 32'hA000 + i);
            set_ld(i < 5, 1, 20 + i, 32'hB000 + i);
            cycle("conf");
        end
        idle();
        chk("conf.cnt_full", 32'(ld_cnt), 32'd4);
        chk("conf.rdy_full", 32'(ld_rdy), 32'd0);
        for (int i = 0; i < 5; i++) cycle("drain");

        // r0 suppression
        set_alu(1, 2, 0, 32'h5555);
        cycle("r0");
        chk("r0.en_const", 32'(wr_en), 32'd0);
        set_alu(1, 2, 1, 32'h6666);
        cycle("r1");
        chk("r1.en_const", 32'(wr_en), 32'd1);
        idle();
        cycle("r_idle");

        // Flush thread 1 under ALU pressure
        for (int i = 0; i < 4; i++) begin
            set_alu(1, 7, 3, 32'hC000 + i);
            set_ld(1, (i % 2) + 1, 4 + i, 32'hD000 + i);
            cycle("fl_fill");
        end
        set_ld(0, 0, 0, 0);
        set_fl(1, 1);
        cycle("fl_kill");
        idle();
        for (int i = 0; i < 5; i++) cycle("fl_drain");
        chk("fl.cnt_empty", 32'(ld_cnt), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            cycle("rnd");
        end

        // Async reset in the middle of traffic
        for (int i = 0; i < 3; i++) begin
            set_alu(1, 1, 7, $urandom);
            set_ld(1, 2, 8, $urandom);
            set_fl(0, 0);
            cycle("pre_rst");
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst.wr_en",  32'(wr_en),  32'd0);
        chk("arst.ld_rdy", 32'(ld_rdy), 32'd1);
        chk("arst.ld_cnt", 32'(ld_cnt), 32'd0);
        model_reset();
        check_outputs("arst");
        idle();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 100; i++) begin
            randomize_inputs();
            cycle("post_rst");
        end
        idle();
        for (int i = 0; i < DEPTH + 1; i++) cycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
